uart_rx_gen2: RTL and testbench

Parametrised second-generation UART receiver: oversampled serial input to parallel words with a valid/ready output. Adds configurable word width, 3-sample majority voting, one or two stop bits, per-frame configuration latching, per-word error flags, overrun reporting and an optional receive FIFO. It sits between the pad-side serial line and any word-oriented consumer (register file, DMA, command parser).

---
 rtl/uart_rx_pkg.sv | 36 +++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_gen2.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_gen2.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and helpers for the uart_rx_gen2 receiver.
//   rx_state_t     - receiver FSM states
//   rx_word_t      - buffered word {data, par_err, stp_err}
//   clamp_prescale - raises prescale values below the legal minimum to it
// Packages cannot take parameters, so the word struct carries the widest
// legal data field; narrower receivers zero-extend into it.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_t;

  localparam int UART_RX_MIN_PRESCALE   = 8;
  localparam int UART_RX_PRESCALE_MAX_W = 16;
  localparam int UART_RX_MAX_DATA_W     = 9;

  typedef struct packed {
    logic [UART_RX_MAX_DATA_W-1:0] data;
    logic                          par_err;
    logic                          stp_err;
  } rx_word_t;

  function automatic logic [UART_RX_PRESCALE_MAX_W-1:0] clamp_prescale(
    input logic [UART_RX_PRESCALE_MAX_W-1:0] p
  );
    if (p < UART_RX_PRESCALE_MAX_W'(UART_RX_MIN_PRESCALE))
      return UART_RX_PRESCALE_MAX_W'(UART_RX_MIN_PRESCALE);
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO of rx_word_t entries.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (pointers only)
//   push       - completed frame offered for storage
//   push_word  - frame contents
//   pop        - consumer accepts the head entry (ignored when empty)
//   pop_word   - head entry, valid while empty is low
//   empty      - no entries stored
//   drop       - push refused because the FIFO stayed full this cycle
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  rx_word_t push_word,
  input  logic     pop,
  output rx_word_t pop_word,
  output logic     empty,
  output logic     drop
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rx_word_t       mem [FIFO_DEPTH];
  logic [AW:0]    wr_q;
  logic [AW:0]    rd_q;
  logic           full;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_word;
  end

  assign pop_word = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: oversampled UART receiver with 3-sample majority voting,
// optional parity, one or two stop bits, per-word error flags and a
// valid/ready output buffer.
// Optional feature macro: UART_RX_FIFO_EN selects a FIFO_DEPTH-entry
// first-word-fall-through FIFO instead of the single holding register.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rx_in             - asynchronous serial line, idles high
//   par_en, par_typ   - parity present, 0 = even / 1 = odd
//   stop2             - two stop bits when high
//   prescale          - clk cycles per bit, clamped to at least 8
//   m_data            - received word, LSB first on the line
//   m_par_err         - parity error flag for m_data
//   m_stp_err         - stop error flag for m_data
//   m_valid, m_ready  - output handshake
//   strt_glitch       - 1-cycle pulse when a start bit is rejected
//   overrun           - 1-cycle pulse when a completed frame is dropped
//   busy              - receiver is inside a frame
module uart_rx_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_par_err,
  output logic                  m_stp_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  strt_glitch,
  output logic                  overrun,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_W);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_rx_gen2: DATA_W must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_gen2: FIFO_DEPTH must be a power of 2, at least 2");
  end

  rx_state_t              state_q, state_d;
  logic                   sync1_q, rxs, rxs_prev_q;
  logic                   par_en_q, par_typ_q, stop2_q;
  logic [PRESCALE_W-1:0]  p_q, mid, cnt_q;
  logic [BCW-1:0]         bit_cnt_q;
  logic [DATA_W-1:0]      shreg_q;
  logic                   s0_q, s1_q, maj;
  logic                   par_err_q, stp_err_q, stp_fin;
  logic                   start_edge, at_m_lo, at_m, at_resolve, at_end;
  logic                   glitch, frame_done, drop;
  logic                   strt_glitch_q, overrun_q;

  // Input synchronizer; both flops idle high like the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs        <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_in;
      rxs        <= sync1_q;
      rxs_prev_q <= rxs;
    end
  end

  assign start_edge = rxs_prev_q & ~rxs;
  assign mid        = p_q >> 1;
  assign at_m_lo    = (cnt_q == mid - 1'b1);
  assign at_m       = (cnt_q == mid);
  assign at_resolve = (cnt_q == mid + 1'b1);
  assign at_end     = (cnt_q == p_q - 1'b1);
  // Third vote is the live sample taken at M+1.
  assign maj        = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  // STOP1 of a one-stop frame sees stp_err_q still cleared from IDLE.
  assign stp_fin    = stp_err_q | ~maj;
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    glitch     = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_START;
      ST_START: begin
        if (at_resolve && maj) begin
          glitch  = 1'b1;
          state_d = ST_IDLE;
        end else if (at_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_end && bit_cnt_q == BCW'(DATA_W - 1))
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (at_end) state_d = ST_STOP1;
      ST_STOP1: begin
        // Completing at mid-bit re-arms early so a fast sender is not lost.
        if (!stop2_q) begin
          if (at_resolve) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (at_end) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (at_resolve) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame configuration is captured at the start edge and held for the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      p_q       <= PRESCALE_W'(UART_RX_MIN_PRESCALE);
    end else if (state_q == ST_IDLE) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      if (start_edge) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        stop2_q   <= stop2;
        p_q       <= PRESCALE_W'(clamp_prescale(UART_RX_PRESCALE_MAX_W'(prescale)));
      end
    end else begin
      cnt_q <= at_end ? '0 : cnt_q + 1'b1;
      if (state_q == ST_DATA && at_end) bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE) begin
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      if (at_m_lo) s0_q <= rxs;
      if (at_m)    s1_q <= rxs;
      if (at_resolve) begin
        if (state_q == ST_DATA)   shreg_q   <= {maj, shreg_q[DATA_W-1:1]};
        if (state_q == ST_PARITY) par_err_q <= (^shreg_q) ^ maj ^ par_typ_q;
        if (state_q == ST_STOP1)  stp_err_q <= ~maj;
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  rx_word_t push_word, pop_word;
  logic     fifo_empty;

  always_comb begin
    push_word         = '0;
    push_word.data    = UART_RX_MAX_DATA_W'(shreg_q);
    push_word.par_err = par_err_q;
    push_word.stp_err = stp_fin;
  end

  uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (frame_done),
    .push_word (push_word),
    .pop       (m_ready),
    .pop_word  (pop_word),
    .empty     (fifo_empty),
    .drop      (drop)
  );

  // Outputs read as zero while empty so the reset values hold.
  assign m_valid   = ~fifo_empty;
  assign m_data    = fifo_empty ? '0   : pop_word.data[DATA_W-1:0];
  assign m_par_err = fifo_empty ? 1'b0 : pop_word.par_err;
  assign m_stp_err = fifo_empty ? 1'b0 : pop_word.stp_err;
`else
  logic              hold_vld_q, hold_par_q, hold_stp_q, push_ok;
  logic [DATA_W-1:0] hold_data_q;

  // An accept in the same cycle frees the register for the new word.
  assign push_ok = frame_done & (~hold_vld_q | m_ready);
  assign drop    = frame_done & ~push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_par_q  <= 1'b0;
      hold_stp_q  <= 1'b0;
    end else if (push_ok) begin
      hold_vld_q  <= 1'b1;
      hold_data_q <= shreg_q;
      hold_par_q  <= par_err_q;
      hold_stp_q  <= stp_fin;
    end else if (hold_vld_q && m_ready) begin
      hold_vld_q  <= 1'b0;
    end
  end

  assign m_valid   = hold_vld_q;
  assign m_data    = hold_data_q;
  assign m_par_err = hold_par_q;
  assign m_stp_err = hold_stp_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      strt_glitch_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      strt_glitch_q <= glitch;
      overrun_q     <= drop;
    end
  end

  assign strt_glitch = strt_glitch_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2: directed bench for uart_rx_gen2 (DATA_W=8, PRESCALE_W=6).
// Accepted words, overrun pulses and start-glitch pulses are collected by a
// negedge monitor; the directed sequence compares them to hand-computed values.
`timescale 1ns/1ps
module tb_uart_rx_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en, par_typ, stop2;
  logic [5:0] prescale;
  logic [7:0] m_data;
  logic       m_par_err, m_stp_err, m_valid, m_ready;
  logic       strt_glitch, overrun, busy;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt  = 0;
  int gl_cnt   = 0;
  logic [9:0] words [$];

  always #5 clk = ~clk;

  uart_rx_gen2 #(.DATA_W(8), .PRESCALE_W(6), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .stop2       (stop2),
    .prescale    (prescale),
    .m_data      (m_data),
    .m_par_err   (m_par_err),
    .m_stp_err   (m_stp_err),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .strt_glitch (strt_glitch),
    .overrun     (overrun),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) words.push_back({m_par_err, m_stp_err, m_data});
      if (overrun)     ovr_cnt = ovr_cnt + 1;
      if (strt_glitch) gl_cnt  = gl_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit s1, input bit s2en, input bit s2,
                            input int p, input int idle);
    rx_in = 1'b0;
    repeat (p) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (p) tick();
    end
    if (pen) begin
      rx_in = pbit;
      repeat (p) tick();
    end
    rx_in = s1;
    repeat (p) tick();
    if (s2en) begin
      rx_in = s2;
      repeat (p) tick();
    end
    rx_in = 1'b1;
    repeat (idle) tick();
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d,
                             input logic pe, input logic se);
    logic [9:0] w;
    chk({tag, "_avail"}, 32'(words.size() > 0), 32'd1);
    if (words.size() > 0) begin
      w = words.pop_front();
      chk({tag, "_data"}, 32'(w[7:0]), 32'(d));
      chk({tag, "_par"},  32'(w[9]),   32'(pe));
      chk({tag, "_stp"},  32'(w[8]),   32'(se));
    end
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; m_ready = 1'b1;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd8;
    repeat (3) tick();
    chk("rst_m_data",  32'(m_data),      32'd0);
    chk("rst_m_valid", 32'(m_valid),     32'd0);
    chk("rst_par",     32'(m_par_err),   32'd0);
    chk("rst_stp",     32'(m_stp_err),   32'd0);
    chk("rst_glitch",  32'(strt_glitch), 32'd0);
    chk("rst_overrun", 32'(overrun),     32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Basic frame, no parity, one stop bit.
    send_frame(8'hA5, 0, 0, 1, 0, 0, 8, 16);
    chk("a5_count", 32'(words.size()), 32'd1);
    expect_word("a5", 8'hA5, 1'b0, 1'b0);

    // Even parity: 0x0F has four ones, correct parity bit is 0.
    par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h0F, 1, 1, 1, 0, 0, 8, 16);
    expect_word("par_bad", 8'h0F, 1'b1, 1'b0);
    send_frame(8'h0F, 1, 0, 1, 0, 0, 8, 16);
    expect_word("par_ok", 8'h0F, 1'b0, 1'b0);
    // Odd parity: the same word needs parity bit 1.
    par_typ = 1'b1;
    send_frame(8'h0F, 1, 1, 1, 0, 0, 8, 16);
    expect_word("odd_ok", 8'h0F, 1'b0, 1'b0);
    par_en = 1'b0; par_typ = 1'b0;

    // Two stop bits with the second one low, then a clean frame.
    stop2 = 1'b1;
    send_frame(8'h33, 0, 0, 1, 1, 0, 8, 24);
    expect_word("stop2_bad", 8'h33, 1'b0, 1'b1);
    send_frame(8'h44, 0, 0, 1, 1, 1, 8, 16);
    expect_word("stop2_ok", 8'h44, 1'b0, 1'b0);
    stop2 = 1'b0;

    // Start glitch: line low for only 3 cycles at prescale 16.
    prescale = 6'd16; gl_cnt = 0;
    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    repeat (40) tick();
    chk("glitch_cnt",   32'(gl_cnt),        32'd1);
    chk("glitch_words", 32'(words.size()),  32'd0);
    chk("glitch_busy",  32'(busy),          32'd0);
    prescale = 6'd8;

    // Back-to-back frames with no idle time between them.
    send_frame(8'h81, 0, 0, 1, 0, 0, 8, 0);
    send_frame(8'h7E, 0, 0, 1, 0, 0, 8, 16);
    expect_word("b2b_0", 8'h81, 1'b0, 1'b0);
    expect_word("b2b_1", 8'h7E, 1'b0, 1'b0);

    // Overrun with the consumer stalled.
    m_ready = 1'b0; ovr_cnt = 0;
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 1, 0, 0, 8, 8);
    repeat (8) tick();
    chk("ovr_cnt",   32'(ovr_cnt), 32'd1);
    chk("ovr_valid", 32'(m_valid), 32'd1);
    chk("ovr_head",  32'(m_data),  32'h01);
    m_ready = 1'b1;
    repeat (8) tick();
    chk("ovr_words", 32'(words.size()), 32'd4);
    for (int i = 1; i <= 4; i++) expect_word("fifo", 8'(i), 1'b0, 1'b0);
`else
    send_frame(8'h11, 0, 0, 1, 0, 0, 8, 16);
    send_frame(8'h22, 0, 0, 1, 0, 0, 8, 16);
    chk("ovr_cnt",   32'(ovr_cnt), 32'd1);
    chk("ovr_valid", 32'(m_valid), 32'd1);
    chk("ovr_hold",  32'(m_data),  32'h11);
    m_ready = 1'b1;
    repeat (4) tick();
    chk("ovr_words", 32'(words.size()), 32'd1);
    expect_word("ovr", 8'h11, 1'b0, 1'b0);
`endif
    chk("ovr_drain", 32'(m_valid), 32'd0);

    // Reset in the middle of DATA of a 0x3C frame (bits LSB first 0,0,1,1,...).
    ovr_cnt = 0;
    rx_in = 1'b0; repeat (8) tick();
    rx_in = 1'b0; repeat (8) tick();
    rx_in = 1'b0; repeat (8) tick();
    rx_in = 1'b1; repeat (8) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) tick();
    chk("mrst_busy",  32'(busy),    32'd0);
    chk("mrst_valid", 32'(m_valid), 32'd0);
    chk("mrst_data",  32'(m_data),  32'd0);
    rst = 1'b0;
    repeat (40) tick();
    chk("mrst_words", 32'(words.size()), 32'd0);
    chk("mrst_ovr",   32'(ovr_cnt),      32'd0);
    chk("mrst_idle",  32'(busy),         32'd0);
    send_frame(8'h3C, 0, 0, 1, 0, 0, 8, 16);
    expect_word("after_rst", 8'h3C, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
